// File: rtl/automata_grid.sv
// automata_grid: ROWSxCOLS cellular automaton with programmable 4-neighbour rule and manual/auto stepping
module automata_grid #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int WRAP     = 1,
    parameter int PERIOD_W = 24,
    parameter int GEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] init_pattern,
    input  logic                 load,
    input  logic [15:0]          rule,
    input  logic                 step_btn,
    input  logic                 run,
    input  logic [PERIOD_W-1:0]  period,
    output logic [ROWS*COLS-1:0] cells,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 running
);
    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {S_OFF, S_LOAD, S_HOLD, S_STEP} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        grid_q, grid_d, nxt;
    logic [GEN_W-1:0]    gen_q, gen_d;
    logic [PERIOD_W-1:0] timer_q, timer_d, last;
    logic                stable_q, stable_d;
    logic                pending_q, pending_d;
    logic                btn_q;
    logic                btn_edge, expire;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int RU = (r + ROWS - 1) % ROWS;
            localparam int RB = (r + 1) % ROWS;
            localparam int CL = (c + COLS - 1) % COLS;
            localparam int CR = (c + 1) % COLS;
            logic nu, nl, nr, nb;
            assign nu = (WRAP != 0 || r > 0)        ? grid_q[RU*COLS+c] : 1'b0;
            assign nb = (WRAP != 0 || r < ROWS - 1) ? grid_q[RB*COLS+c] : 1'b0;
            assign nl = (WRAP != 0 || c > 0)        ? grid_q[r*COLS+CL] : 1'b0;
            assign nr = (WRAP != 0 || c < COLS - 1) ? grid_q[r*COLS+CR] : 1'b0;
            assign nxt[r*COLS+c] = rule[{nu, nl, nr, nb}];
        end
    end

    assign btn_edge = step_btn & ~btn_q;
    assign last     = (period == '0) ? '0 : period - 1'b1;
    assign expire   = (state_q == S_HOLD) && run && (timer_q == last);

    // Next-state and datapath updates; enable low overrides everything and clears state
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        pending_d = pending_q;
        timer_d   = '0;
        case (state_q)
            S_OFF: begin
                grid_d    = '0;
                gen_d     = '0;
                stable_d  = 1'b0;
                pending_d = 1'b0;
                state_d   = enable ? S_LOAD : S_OFF;
            end
            S_LOAD: begin
                grid_d    = init_pattern;
                gen_d     = '0;
                stable_d  = 1'b0;
                pending_d = pending_q | btn_edge;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                timer_d = (run && !expire) ? timer_q + 1'b1 : '0;
                state_d = load ? S_LOAD : (btn_edge || pending_q || expire) ? S_STEP : S_HOLD;
            end
            default: begin
                grid_d    = nxt;
                gen_d     = gen_q + 1'b1;
                stable_d  = (nxt == grid_q);
                pending_d = btn_edge;
                state_d   = S_HOLD;
            end
        endcase
        if (!enable) begin
            state_d   = S_OFF;
            grid_d    = '0;
            gen_d     = '0;
            stable_d  = 1'b0;
            pending_d = 1'b0;
            timer_d   = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_OFF;
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            pending_q <= 1'b0;
            timer_q   <= '0;
            btn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            btn_q     <= step_btn;
        end
    end

    assign cells     = (state_q == S_OFF) ? init_pattern : grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign running   = run && (state_q == S_HOLD || state_q == S_STEP);
endmodule

// File: tb/tb_automata_grid.sv
// tb_automata_grid: directed and randomized checks of automata_grid against a rule-level grid model
module tb_automata_grid;
    localparam int R = 4;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst, enable, load, step_btn, run;
    logic [15:0] init_pattern, rule;
    logic [23:0] period;
    logic [15:0] cells1, cells0, gen1;
    logic [2:0]  gen0;
    logic        stable1, stable0, running1, running0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    automata_grid #(.ROWS(4), .COLS(4), .WRAP(1), .PERIOD_W(24), .GEN_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .init_pattern(init_pattern), .load(load),
        .rule(rule), .step_btn(step_btn), .run(run), .period(period),
        .cells(cells1), .gen_count(gen1), .stable(stable1), .running(running1)
    );

    automata_grid #(.ROWS(4), .COLS(4), .WRAP(0), .PERIOD_W(24), .GEN_W(3)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .init_pattern(init_pattern), .load(load),
        .rule(rule), .step_btn(step_btn), .run(run), .period(period),
        .cells(cells0), .gen_count(gen0), .stable(stable0), .running(running0)
    );

    // One generation: each cell looks up rule with its {U,L,R,B} neighbours
    function automatic logic [15:0] model_next(input logic [15:0] g, input logic [15:0] rl, input bit wrap);
        logic [15:0] o;
        int dr[4];
        int dc[4];
        int idx, rr, cc;
        logic v;
        dr = '{-1, 0, 0, 1};
        dc = '{0, -1, 1, 0};
        o = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                idx = 0;
                for (int k = 0; k < 4; k++) begin
                    rr = r + dr[k];
                    cc = c + dc[k];
                    v = 1'b0;
                    if (wrap) v = g[((rr + R) % R) * C + (cc + C) % C];
                    else if (rr >= 0 && rr < R && cc >= 0 && cc < C) v = g[rr * C + cc];
                    idx = idx * 2 + int'(v);
                end
                o[r * C + c] = rl[idx];
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
    endtask

    task automatic reload(input logic [15:0] v);
        init_pattern = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    logic [15:0] e1, e0, ip, r2;
    int g;

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; step_btn = 1'b0; run = 1'b0;
        period = '0; rule = 16'h6116; init_pattern = 16'h0020;
        tick(2);
        chk("rst_cells", 32'(cells1), 32'h0020);
        chk("rst_gen", 32'(gen1), 32'h0);
        chk("rst_stable", 32'(stable1), 32'h0);
        chk("rst_running", 32'(running1), 32'h0);
        rst = 1'b0;
        tick();
        init_pattern = 16'hBEEF;
        #1;
        chk("off_passthru", 32'(cells1), 32'hBEEF);
        init_pattern = 16'h0020;
        enable = 1'b1;
        tick(2);
        chk("enable_load", 32'(cells1), 32'h0020);
        press();
        chk("single_wrap", 32'(cells1), 32'h0252);
        chk("single_model", 32'(cells1), 32'(model_next(16'h0020, 16'h6116, 1'b1)));
        chk("single_nowrap", 32'(cells0), 32'(model_next(16'h0020, 16'h6116, 1'b0)));
        chk("single_gen", 32'(gen1), 32'h1);
        chk("single_stable", 32'(stable1), 32'h0);

        reload(16'h0001);
        chk("reload_cells", 32'(cells1), 32'h0001);
        chk("reload_gen", 32'(gen1), 32'h0);
        press();
        chk("corner_wrap", 32'(cells1), 32'h101A);
        chk("corner_nowrap", 32'(cells0), 32'h0012);

        rule = 16'h0001;
        reload(16'h0000);
        press();
        chk("zero_r1", 32'(cells1), 32'hFFFF);
        chk("zero_r1_stable", 32'(stable1), 32'h0);
        e0 = model_next(16'h0000, 16'h0001, 1'b0);
        chk("zero_r1_nowrap", 32'(cells0), 32'(e0));
        press();
        chk("ones_r1", 32'(cells1), 32'h0000);
        chk("ones_r1_nowrap", 32'(cells0), 32'(model_next(e0, 16'h0001, 1'b0)));
        rule = 16'h6116;
        press();
        chk("zero_classic", 32'(cells1), 32'h0000);
        chk("zero_classic_stable", 32'(stable1), 32'h1);
        chk("running_off", 32'(running1), 32'h0);

        // auto-step: period 3 then period 0
        rule = 16'($urandom);
        ip = 16'($urandom);
        reload(ip);
        e1 = ip; e0 = ip; g = 0;
        run = 1'b1; period = 24'd3;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i % 4 == 0) begin
                e1 = model_next(e1, rule, 1'b1);
                e0 = model_next(e0, rule, 1'b0);
                g++;
            end
            chk("auto3_gen", 32'(gen1), 32'(g));
            chk("auto3_cells", 32'(cells1), 32'(e1));
        end
        chk("auto3_total", 32'(gen1), 32'd5);
        chk("running_on", 32'(running1), 32'h1);
        period = 24'd0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i % 2 == 0) begin
                e1 = model_next(e1, rule, 1'b1);
                e0 = model_next(e0, rule, 1'b0);
                g++;
            end
            chk("auto0_gen", 32'(gen1), 32'(g));
        end
        chk("auto0_cells", 32'(cells1), 32'(e1));
        chk("nowrap_cells", 32'(cells0), 32'(e0));
        chk("gen_wrap", 32'(gen0), 32'(g % 8));
        run = 1'b0;
        tick(3);
        chk("run_off_gen", 32'(gen1), 32'(g));

        // held button gives exactly one step
        step_btn = 1'b1;
        tick(100);
        step_btn = 1'b0;
        tick();
        e1 = model_next(e1, rule, 1'b1);
        g++;
        chk("held_gen", 32'(gen1), 32'(g));
        chk("held_cells", 32'(cells1), 32'(e1));

        // edges during LOAD and during STEP are each serviced later
        ip = 16'($urandom);
        init_pattern = ip;
        load = 1'b1;
        tick();
        load = 1'b0; step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
        step_btn = 1'b1;
        tick();
        e1 = model_next(ip, rule, 1'b1);
        chk("pend_load_gen", 32'(gen1), 32'h1);
        chk("pend_load_cells", 32'(cells1), 32'(e1));
        step_btn = 1'b0;
        tick(2);
        e1 = model_next(e1, rule, 1'b1);
        chk("pend_step_gen", 32'(gen1), 32'h2);
        chk("pend_step_cells", 32'(cells1), 32'(e1));
        tick(3);
        chk("pend_no_extra", 32'(gen1), 32'h2);

        // load wins over a simultaneous edge
        ip = 16'($urandom);
        init_pattern = ip;
        load = 1'b1; step_btn = 1'b1;
        tick(2);
        chk("load_prio_cells", 32'(cells1), 32'(ip));
        chk("load_prio_gen", 32'(gen1), 32'h0);
        load = 1'b0; step_btn = 1'b0;
        tick();

        // random seeds and rules; rule edits in HOLD do not touch the grid
        for (int i = 0; i < 16; i++) begin
            ip = 16'($urandom);
            rule = 16'($urandom);
            reload(ip);
            r2 = 16'($urandom);
            rule = r2;
            tick(3);
            chk("rnd_hold", 32'(cells1), 32'(ip));
            press();
            e1 = model_next(ip, r2, 1'b1);
            e0 = model_next(ip, r2, 1'b0);
            chk("rnd_wrap", 32'(cells1), 32'(e1));
            chk("rnd_nowrap", 32'(cells0), 32'(e0));
            chk("rnd_gen", 32'(gen1), 32'h1);
            chk("rnd_stable", 32'(stable1), 32'(e1 == ip));
        end

        // enable drop mid-run
        run = 1'b1; period = 24'd1;
        tick(5);
        ip = 16'($urandom);
        init_pattern = ip;
        enable = 1'b0;
        tick();
        chk("dis_cells", 32'(cells1), 32'(ip));
        chk("dis_gen", 32'(gen1), 32'h0);
        chk("dis_stable", 32'(stable1), 32'h0);
        chk("dis_running", 32'(running1), 32'h0);
        enable = 1'b1;
        tick(2);
        chk("reen_cells", 32'(cells1), 32'(ip));
        chk("reen_running", 32'(running1), 32'h1);

        // async reset while a STEP is in flight
        period = 24'd0;
        tick(5);
        chk("pre_rst_gen", 32'(gen1), 32'h2);
        chk("pre_rst_running", 32'(running1), 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_cells", 32'(cells1), 32'(ip));
        chk("arst_gen", 32'(gen1), 32'h0);
        chk("arst_stable", 32'(stable1), 32'h0);
        chk("arst_running", 32'(running1), 32'h0);
        tick();
        rst = 1'b0;
        run = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
